// File: rtl/registro_pkg.sv
// Shared constants and helpers for the parametrised register pipeline.
// REGISTRO_PARITY_EN adds a parity bit per stage (see registro_etapa).
package registro_pkg;

    localparam int unsigned REG_DEF_WIDTH     = 5;
    localparam int unsigned REG_DEF_DEPTH     = 4;
    localparam int unsigned REG_DEF_RESET_VAL = 0;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/registro_pipeline_param_if.sv
// Handshake bundle of the register pipeline: producer side, consumer side, flush, count.
// Under REGISTRO_PARITY_EN the bundle also carries par_o.
interface registro_pipeline_param_if
    import registro_pkg::*;
#(
    parameter int unsigned WIDTH = REG_DEF_WIDTH,
    parameter int unsigned DEPTH = REG_DEF_DEPTH
);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] D_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] Q_o;
    logic [CW-1:0]    count_o;
`ifdef REGISTRO_PARITY_EN
    logic             par_o;
`endif

    modport master (
        output flush_i, in_valid_i, D_i, out_ready_i,
`ifdef REGISTRO_PARITY_EN
        input  par_o,
`endif
        input  in_ready_o, out_valid_o, Q_o, count_o
    );

    modport slave (
        input  flush_i, in_valid_i, D_i, out_ready_i,
`ifdef REGISTRO_PARITY_EN
        output par_o,
`endif
        output in_ready_o, out_valid_o, Q_o, count_o
    );

endinterface

// File: rtl/registro_etapa.sv
// One pipeline stage: data register, valid flag and, under REGISTRO_PARITY_EN, a parity bit.
// Loads from upstream when it can accept; drops its valid when the word leaves or on flush.
module registro_etapa
    import registro_pkg::*;
#(
    parameter int unsigned      WIDTH     = REG_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(REG_DEF_RESET_VAL)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
`ifdef REGISTRO_PARITY_EN
    input  logic             up_par_i,
    output logic             par_o,
`endif
    input  logic             accept_i,
    input  logic             dn_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
`ifdef REGISTRO_PARITY_EN
        logic             par;
`endif
    } stage_t;

    stage_t stage_q, stage_d;

    // Flush only clears the valid flag; the payload stays put.
    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d.valid = 1'b0;
        end else if (up_valid_i && accept_i) begin
            stage_d.valid = 1'b1;
            stage_d.data  = up_data_i;
`ifdef REGISTRO_PARITY_EN
            stage_d.par   = up_par_i;
`endif
        end else if (dn_ready_i) begin
            stage_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q.valid <= 1'b0;
            stage_q.data  <= RESET_VAL;
`ifdef REGISTRO_PARITY_EN
            stage_q.par   <= ^RESET_VAL;
`endif
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_o = stage_q.valid;
    assign data_o  = stage_q.data;
`ifdef REGISTRO_PARITY_EN
    assign par_o   = stage_q.par;
`endif

endmodule

// File: rtl/registro_pipeline_param.sv
// Stallable DEPTH-stage register chain with collapsing bubbles, flush and occupancy count.
// Define REGISTRO_PARITY_EN to carry even parity of each word alongside it (par_o).
module registro_pipeline_param
    import registro_pkg::*;
#(
    parameter int unsigned      WIDTH     = REG_DEF_WIDTH,
    parameter int unsigned      DEPTH     = REG_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(REG_DEF_RESET_VAL)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    registro_pipeline_param_if.slave bus
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data     [DEPTH];
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] up_data  [DEPTH];
    logic [DEPTH:0]   accept;
`ifdef REGISTRO_PARITY_EN
    logic             par      [DEPTH];
    logic             up_par   [DEPTH];
`endif
    logic             in_ready;
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    count_q, count_d;

    // Ready ripples back from the consumer: a stage frees up if it is empty or its successor can take its word.
    always_comb begin
        accept        = '0;
        accept[DEPTH] = bus.out_ready_i;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            accept[k] = !valid[k] || accept[k+1];
        end
    end

    assign in_ready = accept[0] && !bus.flush_i;
    assign in_xfer  = bus.in_valid_i && in_ready;
    assign out_xfer = valid[DEPTH-1] && bus.out_ready_i;

    always_comb begin
        up_valid[0] = in_xfer;
        up_data[0]  = bus.D_i;
`ifdef REGISTRO_PARITY_EN
        up_par[0]   = ^bus.D_i;
`endif
        for (int k = 1; k < int'(DEPTH); k++) begin
            up_valid[k] = valid[k-1];
            up_data[k]  = data[k-1];
`ifdef REGISTRO_PARITY_EN
            up_par[k]   = par[k-1];
`endif
        end
    end

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
        registro_etapa #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_etapa (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (bus.flush_i),
            .up_valid_i (up_valid[k]),
            .up_data_i  (up_data[k]),
`ifdef REGISTRO_PARITY_EN
            .up_par_i   (up_par[k]),
            .par_o      (par[k]),
`endif
            .accept_i   (accept[k]),
            .dn_ready_i (accept[k+1]),
            .valid_o    (valid[k]),
            .data_o     (data[k])
        );
    end

    // Occupancy tracks transfers only; simultaneous in and out cancel.
    always_comb begin
        count_d = count_q;
        if (bus.flush_i) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = valid[DEPTH-1];
    assign bus.Q_o         = data[DEPTH-1];
    assign bus.count_o     = count_q;
`ifdef REGISTRO_PARITY_EN
    assign bus.par_o       = par[DEPTH-1];
`endif

endmodule

// File: tb/tb_registro_pipeline_param.sv
// Directed plus randomized bench for registro_pipeline_param (WIDTH=5, DEPTH=4, RESET_VAL=0).
// Checks par_o as well when REGISTRO_PARITY_EN is defined.
module tb_registro_pipeline_param;

    localparam int W = 5;
    localparam int D = 4;

    logic clk;
    logic rst;

    registro_pipeline_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

    registro_pipeline_param #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (5'h00)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference: slot occupancy/payload per position, plus an in-order FIFO of accepted words.
    bit           mv [D];
    logic [W-1:0] md [D];
    bit           mp [D];
    logic [W-1:0] sb [$];
    logic [W-1:0] obs_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int occ();
        int n = 0;
        for (int k = 0; k < D; k++) n += int'(mv[k]);
        return n;
    endfunction

    task automatic model_update(input logic iv, input logic [W-1:0] d, input logic ordy,
                                input logic fl, input logic rs, input bit check);
        bit in_x;
        bit out_x;
        if (rs) begin
            for (int k = 0; k < D; k++) begin
                mv[k] = 0;
                md[k] = '0;
                mp[k] = 0;
            end
            sb.delete();
            return;
        end
        in_x  = iv && (occ() < D || ordy) && !fl;
        out_x = mv[D-1] && ordy;
        if (out_x) begin
            if (sb.size() == 0) begin
                if (check) chk("order_underflow", 32'(sb.size()), 32'd1);
            end else begin
                logic [W-1:0] exp_w;
                exp_w = sb.pop_front();
                if (check) chk("order", 32'(obs_q), 32'(exp_w));
            end
        end
        if (fl) begin
            for (int k = 0; k < D; k++) mv[k] = 0;
            sb.delete();
            return;
        end
        if (out_x) mv[D-1] = 0;
        for (int k = D - 2; k >= 0; k--) begin
            if (mv[k] && !mv[k+1]) begin
                mv[k+1] = 1;
                md[k+1] = md[k];
                mp[k+1] = mp[k];
                mv[k]   = 0;
            end
        end
        if (in_x) begin
            mv[0] = 1;
            md[0] = d;
            mp[0] = ^d;
            sb.push_back(d);
        end
    endtask

    task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic rs, input bit check);
        bus.in_valid_i  = iv;
        bus.D_i         = d;
        bus.out_ready_i = ordy;
        bus.flush_i     = fl;
        rst             = rs;
        @(negedge clk);
        obs_q = bus.Q_o;
        if (check) begin
            chk("in_ready",  32'(bus.in_ready_o),  32'((occ() < D || ordy) && !fl));
            chk("out_valid", 32'(bus.out_valid_o), 32'(mv[D-1]));
            chk("q",         32'(bus.Q_o),         32'(md[D-1]));
            chk("count",     32'(bus.count_o),     32'(occ()));
`ifdef REGISTRO_PARITY_EN
            chk("par",       32'(bus.par_o),       32'(mp[D-1]));
`endif
        end
        @(posedge clk);
        model_update(iv, d, ordy, fl, rs, check);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < D; k++) begin
            mv[k] = 0;
            md[k] = '0;
            mp[k] = 0;
        end

        // Reset held two cycles with a word offered
        cyc(1'b1, 5'h1F, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 5'h1F, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.in_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_q",         32'(bus.Q_o),         32'h00);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_count",     32'(bus.count_o),     32'd0);
        chk("rst_in_ready",  32'(bus.in_ready_o),  32'd1);

        // Latency: visible exactly three edges after the accepting edge
        cyc(1'b1, 5'h0A, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lat_early_valid", 32'(bus.out_valid_o), 32'd0);
        cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lat_valid", 32'(bus.out_valid_o), 32'd1);
        chk("lat_q",     32'(bus.Q_o),         32'h0A);
        cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lat_gone",  32'(bus.out_valid_o), 32'd0);
        chk("lat_count", 32'(bus.count_o),     32'd0);

        // Streaming 0..15 back to back
        for (int i = 0; i < 16; i++) cyc(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b1);
        chk("stream_count", 32'(bus.count_o), 32'd4);
        for (int i = 0; i < 5; i++) cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Backpressure: six offered, four accepted, first word held
        for (int i = 0; i < 6; i++) cyc(1'b1, W'(5'h10 + i), 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
        chk("bp_count",    32'(bus.count_o),    32'd4);
        chk("bp_q",        32'(bus.Q_o),        32'h10);
        for (int i = 0; i < 6; i++) cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Bubble collapse under stall
        cyc(1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'h03, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bub_count", 32'(bus.count_o), 32'd2);
        chk("bub_q",     32'(bus.Q_o),     32'h01);
        cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("bub_next_q",     32'(bus.Q_o),         32'h03);
        chk("bub_next_valid", 32'(bus.out_valid_o), 32'd1);
        cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flush with three stored words; offered word refused
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(5'h0C + i), 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'h1E, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("fl_count", 32'(bus.count_o),     32'd0);
        chk("fl_valid", 32'(bus.out_valid_o), 32'd0);
        cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fl_after_count", 32'(bus.count_o), 32'd0);

        // Mid-stream reset
        for (int i = 0; i < 5; i++) cyc(1'b1, W'(5'h15 + i), 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5'h1B, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("mrst_q",     32'(bus.Q_o),         32'h00);
        chk("mrst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mrst_count", 32'(bus.count_o),     32'd0);

`ifdef REGISTRO_PARITY_EN
        cyc(1'b1, 5'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("par_q",   32'(bus.Q_o),   32'h07);
        chk("par_bit", 32'(bus.par_o), 32'd1);
        cyc(1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            logic iv, ordy, fl, rs;
            logic [W-1:0] d;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 29) == 0);
            rs   = ($urandom_range(0, 79) == 0);
            d    = W'($urandom);
            cyc(iv, d, ordy, fl, rs, !rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
